// File: rtl/noise_removal_ctrl.sv
// noise_removal_ctrl: learns a per-lane background noise estimate by averaging periods, then subtracts it from a handshaked stream
// Ports: i_clk/i_rst clock and async active-high reset; i_start restarts learning;
// i_in_valid/o_in_ready/i_period_data input beat (16 x s8); o_out_valid/i_out_ready/o_data_no_noise output beat (16 x s8);
// o_bg_noise 16 x s16 estimate, o_noise_valid estimate complete, o_learning high in LEARN.
module noise_removal_ctrl #(
  parameter int AVG_LOG2 = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [127:0] i_period_data,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_data_no_noise,
  output logic [255:0] o_bg_noise,
  output logic         o_noise_valid,
  output logic         o_learning
);
  typedef enum logic [1:0] {S_IDLE, S_LEARN, S_RUN} state_t;
  localparam logic [8:0] LAST = 9'((1 << AVG_LOG2) - 1);
  state_t       r_state;
  logic [255:0] r_acc, r_bg, w_acc_next, w_bg_next;
  logic [127:0] r_data, w_diff;
  logic [8:0]   r_cnt;
  logic         r_out_valid, r_noise_valid, r_learning;
  logic         w_in_ready, w_accept, w_run_accept;
  // Start always blocks the input beat; RUN stalls only while a held output is not being taken
  assign w_in_ready = !i_start && (r_state == S_LEARN || (r_state == S_RUN && (!r_out_valid || i_out_ready)));
  assign w_accept = i_in_valid && w_in_ready;
  assign w_run_accept = w_accept && r_state == S_RUN;
  for (genvar g = 0; g < 16; g++) begin : g_lane
    logic signed [15:0] w_lane, w_sum, w_dif;
    assign w_lane = {{8{i_period_data[8*g+7]}}, i_period_data[8*g +: 8]};
    assign w_sum = $signed(r_acc[16*g +: 16]) + w_lane;
    assign w_acc_next[16*g +: 16] = w_sum;
    assign w_bg_next[16*g +: 16] = w_sum >>> AVG_LOG2;
    assign w_dif = w_lane - $signed(r_bg[16*g +: 16]);
    assign w_diff[8*g +: 8] = w_dif[7:0];
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_acc         <= '0;
      r_bg          <= '0;
      r_data        <= '0;
      r_cnt         <= '0;
      r_out_valid   <= 1'b0;
      r_noise_valid <= 1'b0;
      r_learning    <= 1'b0;
    end else begin
      // a pending output survives a restart and drains on i_out_ready
      r_out_valid <= w_run_accept ? 1'b1 : (i_out_ready ? 1'b0 : r_out_valid);
      if (w_run_accept) r_data <= w_diff;
      if (i_start) begin
        r_state       <= S_LEARN;
        r_acc         <= '0;
        r_cnt         <= '0;
        r_noise_valid <= 1'b0;
        r_learning    <= 1'b1;
      end else if (r_state == S_LEARN && w_accept) begin
        if (r_cnt == LAST) begin
          r_bg          <= w_bg_next;
          r_noise_valid <= 1'b1;
          r_learning    <= 1'b0;
          r_state       <= S_RUN;
        end else begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 9'd1;
        end
      end
    end
  end
  assign o_in_ready      = w_in_ready;
  assign o_out_valid     = r_out_valid;
  assign o_data_no_noise = r_data;
  assign o_bg_noise      = r_bg;
  assign o_noise_valid   = r_noise_valid;
  assign o_learning      = r_learning;
endmodule

// File: tb/tb_noise_removal_ctrl.sv
// tb_noise_removal_ctrl: randomized self-checking bench for noise_removal_ctrl against a floor-average/subtract model
module tb_noise_removal_ctrl;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [127:0] period_data = '0;
  logic in_ready, out_valid, noise_valid, learning;
  logic [127:0] data;
  logic [255:0] bg;
  logic in_ready0, out_valid0, noise_valid0, learning0;
  logic [127:0] data0;
  logic [255:0] bg0;
  int n_cmp = 0, n_err = 0;
  int msum[16];
  int mbg[16];
  logic s_in_ready, s_out_valid, s0_in_ready;
  logic [127:0] s_data;

  noise_removal_ctrl #(.AVG_LOG2(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_period_data(period_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_data_no_noise(data), .o_bg_noise(bg), .o_noise_valid(noise_valid), .o_learning(learning));
  noise_removal_ctrl #(.AVG_LOG2(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid), .o_in_ready(in_ready0),
    .i_period_data(period_data), .o_out_valid(out_valid0), .i_out_ready(out_ready),
    .o_data_no_noise(data0), .o_bg_noise(bg0), .o_noise_valid(noise_valid0), .o_learning(learning0));

  always #5 clk = ~clk;

  function automatic int fdiv(int a, int n);
    int q;
    q = a / n;
    if ((a % n) != 0 && a < 0) q--;
    return q;
  endfunction

  function automatic void model_clear();
    for (int l = 0; l < 16; l++) msum[l] = 0;
  endfunction

  function automatic void model_add(logic [127:0] d);
    for (int l = 0; l < 16; l++) msum[l] += int'($signed(d[8*l +: 8]));
  endfunction

  function automatic void model_finish(int n);
    for (int l = 0; l < 16; l++) mbg[l] = fdiv(msum[l], n);
  endfunction

  function automatic logic [127:0] exp_out(logic [127:0] d);
    logic [127:0] r;
    int v;
    r = '0;
    for (int l = 0; l < 16; l++) begin
      v = int'($signed(d[8*l +: 8])) - mbg[l];
      r[8*l +: 8] = v[7:0];
    end
    return r;
  endfunction

  function automatic logic [255:0] exp_bg();
    logic [255:0] r;
    int t;
    r = '0;
    for (int l = 0; l < 16; l++) begin
      t = mbg[l];
      r[16*l +: 16] = t[15:0];
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // drive one cycle from posedge+1, sample mid-cycle, return at next posedge+1
  task automatic step(input logic v, input logic [127:0] d, input logic s, input logic r);
    in_valid = v;
    period_data = d;
    start = s;
    out_ready = r;
    #2;
    s_in_ready = in_ready;
    s_out_valid = out_valid;
    s_data = data;
    s0_in_ready = in_ready0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({in_ready, out_valid, noise_valid, learning} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {in_ready, out_valid, noise_valid, learning}); end
    n_cmp++; if (data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", data); end
    n_cmp++; if (bg !== '0 || bg0 !== '0) begin n_err++; $display("FAIL reset_bg: got %h want 0", bg); end
    for (int l = 0; l < 16; l++) mbg[l] = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    step(1, rnd(), 0, 1);
    n_cmp++; if (s_in_ready !== 1'b0 || learning !== 1'b0) begin n_err++; $display("FAIL idle_ready: in_ready=%b learning=%b want 0 0", s_in_ready, learning); end
  endtask

  task automatic test_basic();
    step(0, '0, 1, 1);
    n_cmp++; if (learning !== 1'b1 || noise_valid !== 1'b0) begin n_err++; $display("FAIL basic_start: learning=%b noise_valid=%b want 1 0", learning, noise_valid); end
    model_clear();
    for (int k = 0; k < 4; k++) begin
      step(1, {16{8'h05}}, 0, 1);
      model_add({16{8'h05}});
      n_cmp++; if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL basic_learn_ready: got %b want 1", s_in_ready); end
    end
    model_finish(4);
    n_cmp++; if (bg !== {16{16'h0005}}) begin n_err++; $display("FAIL basic_bg: got %h want %h", bg, {16{16'h0005}}); end
    n_cmp++; if (noise_valid !== 1'b1 || learning !== 1'b0) begin n_err++; $display("FAIL basic_done: noise_valid=%b learning=%b want 1 0", noise_valid, learning); end
    step(1, {16{8'h08}}, 0, 1);
    n_cmp++; if (out_valid !== 1'b1 || data !== {16{8'h03}}) begin n_err++; $display("FAIL basic_out: valid=%b data=%h want 1 %h", out_valid, data, {16{8'h03}}); end
    step(0, '0, 0, 1);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_negative();
    int lv[4] = '{-1, -2, -2, -2};
    logic [127:0] d, e;
    step(0, '0, 1, 1);
    model_clear();
    for (int k = 0; k < 4; k++) begin
      d = rnd();
      d[7:0] = 8'(lv[k]);
      step(1, d, 0, 1);
      model_add(d);
    end
    model_finish(4);
    n_cmp++; if (bg[15:0] !== 16'hFFFE) begin n_err++; $display("FAIL neg_lane0: got %h want fffe", bg[15:0]); end
    n_cmp++; if (bg !== exp_bg()) begin n_err++; $display("FAIL neg_bg: got %h want %h", bg, exp_bg()); end
    d = rnd();
    d[7:0] = 8'h7F;
    e = exp_out(d);
    step(1, d, 0, 1);
    n_cmp++; if (data[7:0] !== 8'h81) begin n_err++; $display("FAIL neg_wrap: got %h want 81", data[7:0]); end
    n_cmp++; if (data !== e) begin n_err++; $display("FAIL neg_out: got %h want %h", data, e); end
    step(0, '0, 0, 1);
  endtask

  task automatic test_random_stream();
    logic [127:0] q[$];
    logic [127:0] d, hold_data, e;
    logic v, r, hold;
    step(0, '0, 1, 1);
    model_clear();
    for (int k = 0; k < 4; k++) begin
      d = rnd();
      step(1, d, 0, 1);
      model_add(d);
    end
    model_finish(4);
    n_cmp++; if (bg !== exp_bg()) begin n_err++; $display("FAIL rnd_bg: got %h want %h", bg, exp_bg()); end
    hold = 1'b0;
    hold_data = '0;
    for (int c = 0; c < 120; c++) begin
      v = ($urandom % 4) != 0;
      r = ($urandom % 3) != 0;
      d = rnd();
      step(v, d, 0, r);
      if (hold) begin
        n_cmp++; if (s_out_valid !== 1'b1 || s_data !== hold_data) begin n_err++; $display("FAIL rnd_stable: valid=%b data=%h want 1 %h", s_out_valid, s_data, hold_data); end
      end
      n_cmp++; if (s_in_ready !== (!s_out_valid || r)) begin n_err++; $display("FAIL rnd_in_ready: got %b want %b", s_in_ready, !s_out_valid || r); end
      if (s_out_valid && r) begin
        e = (q.size() > 0) ? q.pop_front() : 'x;
        n_cmp++; if (s_data !== e) begin n_err++; $display("FAIL rnd_out: got %h want %h", s_data, e); end
      end
      if (v && s_in_ready) q.push_back(exp_out(d));
      hold = s_out_valid && !r;
      hold_data = s_data;
    end
    for (int k = 0; k < 4; k++) begin
      step(0, '0, 0, 1);
      if (s_out_valid) begin
        e = (q.size() > 0) ? q.pop_front() : 'x;
        n_cmp++; if (s_data !== e) begin n_err++; $display("FAIL rnd_drain_out: got %h want %h", s_data, e); end
      end
    end
    n_cmp++; if (q.size() != 0 || out_valid !== 1'b0) begin n_err++; $display("FAIL rnd_drain: left=%0d valid=%b want 0 0", q.size(), out_valid); end
  endtask

  task automatic test_backpressure();
    logic [127:0] d1, d2, d3;
    d1 = rnd(); d2 = rnd(); d3 = rnd();
    step(1, d1, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(1, d2, 0, 0);
      n_cmp++; if (s_in_ready !== 1'b0 || s_out_valid !== 1'b1 || s_data !== exp_out(d1)) begin n_err++; $display("FAIL bp_hold: ready=%b valid=%b data=%h want 0 1 %h", s_in_ready, s_out_valid, s_data, exp_out(d1)); end
    end
    step(1, d2, 0, 1);
    n_cmp++; if (s_in_ready !== 1'b1 || s_data !== exp_out(d1)) begin n_err++; $display("FAIL bp_release: ready=%b data=%h want 1 %h", s_in_ready, s_data, exp_out(d1)); end
    step(1, d3, 0, 1);
    n_cmp++; if (s_out_valid !== 1'b1 || s_data !== exp_out(d2)) begin n_err++; $display("FAIL bp_next: valid=%b data=%h want 1 %h", s_out_valid, s_data, exp_out(d2)); end
    step(0, '0, 0, 1);
    n_cmp++; if (s_out_valid !== 1'b1 || s_data !== exp_out(d3)) begin n_err++; $display("FAIL bp_last: valid=%b data=%h want 1 %h", s_out_valid, s_data, exp_out(d3)); end
    step(0, '0, 0, 1);
    n_cmp++; if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL bp_dup: got %b want 0", s_out_valid); end
  endtask

  task automatic test_start_pending();
    logic [127:0] da, ea, d;
    logic [255:0] old_bg;
    da = rnd();
    ea = exp_out(da);
    old_bg = exp_bg();
    step(1, da, 0, 1);
    step(1, rnd(), 1, 0);
    n_cmp++; if (s_in_ready !== 1'b0 || s_out_valid !== 1'b1) begin n_err++; $display("FAIL sp_block: ready=%b valid=%b want 0 1", s_in_ready, s_out_valid); end
    n_cmp++; if (learning !== 1'b1 || noise_valid !== 1'b0) begin n_err++; $display("FAIL sp_state: learning=%b noise_valid=%b want 1 0", learning, noise_valid); end
    n_cmp++; if (out_valid !== 1'b1 || data !== ea) begin n_err++; $display("FAIL sp_held: valid=%b data=%h want 1 %h", out_valid, data, ea); end
    step(0, '0, 0, 0);
    step(0, '0, 0, 1);
    n_cmp++; if (s_out_valid !== 1'b1 || s_data !== ea) begin n_err++; $display("FAIL sp_deliver: valid=%b data=%h want 1 %h", s_out_valid, s_data, ea); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sp_cleared: got %b want 0", out_valid); end
    model_clear();
    for (int k = 0; k < 4; k++) begin
      d = rnd();
      step(1, d, 0, 1);
      model_add(d);
      if (k == 2) begin
        n_cmp++; if (bg !== old_bg) begin n_err++; $display("FAIL sp_old_bg: got %h want %h", bg, old_bg); end
      end
    end
    model_finish(4);
    n_cmp++; if (bg !== exp_bg() || noise_valid !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL sp_new_bg: got %h nv=%b ov=%b want %h 1 0", bg, noise_valid, out_valid, exp_bg()); end
  endtask

  task automatic test_reset_mid_learn();
    step(0, '0, 1, 1);
    step(1, rnd(), 0, 1);
    step(1, rnd(), 0, 1);
    rst = 1'b1;
    #1;
    for (int l = 0; l < 16; l++) mbg[l] = 0;
    n_cmp++; if ({in_ready, out_valid, noise_valid, learning} !== 4'b0) begin n_err++; $display("FAIL rml_flags: got %b want 0000", {in_ready, out_valid, noise_valid, learning}); end
    n_cmp++; if (bg !== '0 || data !== '0) begin n_err++; $display("FAIL rml_regs: bg=%h data=%h want 0", bg, data); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step(1, rnd(), 0, 1);
      n_cmp++; if (s_in_ready !== 1'b0 || learning !== 1'b0 || noise_valid !== 1'b0) begin n_err++; $display("FAIL rml_idle: ready=%b learning=%b nv=%b want 0 0 0", s_in_ready, learning, noise_valid); end
    end
    step(0, '0, 1, 1);
    model_clear();
    for (int k = 0; k < 4; k++) begin
      step(1, {16{8'h10}}, 0, 1);
      model_add({16{8'h10}});
    end
    model_finish(4);
    n_cmp++; if (bg !== {16{16'h0010}}) begin n_err++; $display("FAIL rml_bg: got %h want %h", bg, {16{16'h0010}}); end
  endtask

  task automatic test_avg0();
    logic [127:0] d, e;
    int v;
    step(0, '0, 1, 1);
    n_cmp++; if (learning0 !== 1'b1 || noise_valid0 !== 1'b0) begin n_err++; $display("FAIL a0_start: learning=%b nv=%b want 1 0", learning0, noise_valid0); end
    step(1, {16{8'h80}}, 0, 1);
    n_cmp++; if (s0_in_ready !== 1'b1) begin n_err++; $display("FAIL a0_ready: got %b want 1", s0_in_ready); end
    n_cmp++; if (bg0 !== {16{16'hFF80}} || noise_valid0 !== 1'b1 || learning0 !== 1'b0) begin n_err++; $display("FAIL a0_bg: got %h nv=%b lr=%b want %h 1 0", bg0, noise_valid0, learning0, {16{16'hFF80}}); end
    d = rnd();
    e = '0;
    for (int l = 0; l < 16; l++) begin
      v = int'($signed(d[8*l +: 8])) + 128;
      e[8*l +: 8] = v[7:0];
    end
    step(1, d, 0, 1);
    n_cmp++; if (s0_in_ready !== 1'b1 || out_valid0 !== 1'b1 || data0 !== e) begin n_err++; $display("FAIL a0_run: ready=%b valid=%b data=%h want 1 1 %h", s0_in_ready, out_valid0, data0, e); end
    step(0, '0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_random_stream();
    test_backpressure();
    test_start_pending();
    test_reset_mid_learn();
    test_avg0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
